cvxif_mac_copro: RTL and testbench
==================================

# cvxif_mac_copro

CV-X-IF responder coprocessor for the cv32a60x core, which has the CV-X-IF extension enabled. It sits on the far side of the core's CV-X-IF interface and implements custom-0 multiply-accumulate instructions over a private XLEN-bit accumulator. It accepts one offloaded instruction at a time, waits for the core's commit/kill decision, executes over a fixed multi-cycle latency, and returns the register writeback through the result channel.

## Interface
- XLEN, 32, datapath/accumulator width
- IdWidth, 4, instruction id width (matches ScoreboardEntries id space)
- MulLatency, 3, execute cycles (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- issue_valid_i  in  1  core offers instruction
- issue_ready_o  out  1  coprocessor can take an instruction
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands (always valid with issue_valid_i)
- issue_accept_o  out  1  instruction is ours (combinational, valid with issue_valid_i)
- issue_writeback_o  out  1  instruction will write rd (equals issue_accept_o)
- commit_valid_i  in  1  commit decision strobe
- commit_id_i  in  IdWidth  id being decided
- commit_kill_i  in  1  1 = discard, 0 = execute
- result_valid_o  out  1  result available
- result_ready_i  in  1  core consumes result
- result_id_o  out  IdWidth  id of result
- result_data_o  out  XLEN  rd value
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable (1 whenever result_valid_o)

## Operation
- Decode: accept iff opcode == 7'b0001011 and funct3 in {000 MAC, 001 CLR, 010 RD}; other funct3 or opcode -> accept=0, writeback=0, nothing latched.
- MAC: acc <= acc + low XLEN bits of rs1*rs2 (mod 2^XLEN); rd <= new acc.
- CLR: rd <= old acc; acc <= 0.
- RD: rd <= acc; acc unchanged.
- FSM states: IDLE, WAIT_COMMIT, EXEC, RESP.
- IDLE: issue_ready_o=1. On issue_valid_i & accept, latch id, rd, funct3, rs1, rs2.
  - If the commit for the same id arrives in the same cycle (commit_kill_i=0), go to EXEC; if killed in that cycle, stay in IDLE.
  - Otherwise go to WAIT_COMMIT.
- WAIT_COMMIT: issue_ready_o=0. Commits with a non-matching id are ignored. On a matching id: kill -> IDLE (acc untouched); commit -> EXEC with cnt=MulLatency-1.
- EXEC: cnt decrements each cycle. When cnt==0, compute the result, update acc, load the result registers, and go to RESP.
- RESP: result_valid_o=1, all result fields stable. On result_ready_i -> IDLE.
- No new issue is accepted until the return to IDLE (single outstanding instruction).

## Timing
- Reset values: state IDLE, acc 0, issue_ready_o 1, result_valid_o 0, result_id_o/data/rd 0, result_we_o 0, cnt 0.
- issue_accept_o/writeback are combinational from issue_instr_i. They are valid only in cycles where issue_valid_i & issue_ready_o.
- Latency from commit handshake to result_valid_o: MulLatency+1 cycles (e.g. 4 with default). Same-cycle issue+commit gives the same latency counted from the issue cycle.
- result_valid_o deasserts the cycle after the result_ready_i handshake. The earliest next issue_ready_o=1 is that same cycle.
- result_ready_i is held high in advance: the handshake completes in the first RESP cycle.
- Async reset mid-EXEC/RESP: immediately returns to IDLE and clears acc, and any pending result is dropped.

## Structure
- Package cvxif_mac_pkg:
  - OPCODE_CUSTOM0
  - FUNCT3_MAC/CLR/RD constants
  - state_e enum
  - issue_latch_t struct (id, rd, funct3, rs1, rs2)
- Sub-module cvxif_mac_decoder: combinational, instr -> accept, op, rd.
- Top cvxif_mac_copro holds the FSM, counter, accumulator, and result registers.

## Test plan
- Reset, then issue MAC rs1=3, rs2=5, commit next cycle -> result_valid_o 4 cycles after commit, data=15, rd matches, acc=15.
- MAC 0xFFFF_FFFF*2 with acc=15 -> data=0x0000_000D (wrap mod 2^32).
- Issue MAC, commit with kill=1 -> no result_valid_o, acc unchanged, issue_ready_o=1 the next cycle.
- Unknown funct3=111 with issue_valid_i -> accept=0, issue_ready_o stays 1, no state change.
- CLR with acc=42, result_ready_i low for 5 cycles -> data=42 held stable, then RD returns 0.
- Same-cycle issue+commit (id=9) while a commit for id=3 arrives in WAIT_COMMIT of another instruction -> non-matching commit ignored, matching commit executes.

Source files
------------

// File: rtl/cvxif_mac_pkg.sv
// Shared constants and types for the CV-X-IF multiply-accumulate coprocessor.
// Latch struct widths follow PKG_XLEN/PKG_ID_WIDTH; keep them equal to the top's parameters.
package cvxif_mac_pkg;

  localparam int PKG_XLEN     = 32;
  localparam int PKG_ID_WIDTH = 4;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] FUNCT3_MAC     = 3'b000;
  localparam logic [2:0] FUNCT3_CLR     = 3'b001;
  localparam logic [2:0] FUNCT3_RD      = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_COMMIT,
    S_EXEC,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [PKG_ID_WIDTH-1:0] id;
    logic [4:0]              rd;
    logic [2:0]              funct3;
    logic [PKG_XLEN-1:0]     rs1;
    logic [PKG_XLEN-1:0]     rs2;
  } issue_latch_t;

  function automatic logic is_mac_funct3(input logic [2:0] f);
    return (f == FUNCT3_MAC) || (f == FUNCT3_CLR) || (f == FUNCT3_RD);
  endfunction

endpackage

// File: rtl/cvxif_mac_decoder.sv
// Combinational decode of offered instruction words into accept, op and rd.
module cvxif_mac_decoder
  import cvxif_mac_pkg::*;
(
  input  logic [31:0] instr,
  output logic        accept,
  output logic [2:0]  op,
  output logic [4:0]  rd
);

  logic unused_bits;

  assign op          = instr[14:12];
  assign rd          = instr[11:7];
  assign accept      = (instr[6:0] == OPCODE_CUSTOM0) && is_mac_funct3(instr[14:12]);
  assign unused_bits = ^instr[31:15];

endmodule

// File: rtl/cvxif_mac_copro.sv
// CV-X-IF responder: single-outstanding custom-0 MAC/CLR/RD over a private accumulator.
//   state         | meaning
//   S_IDLE        | ready for an offload; same-cycle commit may skip straight to EXEC
//   S_WAIT_COMMIT | holding latched operands until commit/kill for our id
//   S_EXEC        | fixed-latency countdown; result and acc update at cnt==0
//   S_RESP        | result presented until result_ready_i
module cvxif_mac_copro
  import cvxif_mac_pkg::*;
#(
  parameter int XLEN       = PKG_XLEN,
  parameter int IdWidth    = PKG_ID_WIDTH,
  parameter int MulLatency = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int CntW = (MulLatency > 1) ? $clog2(MulLatency) : 1;
  localparam logic [CntW-1:0] CNT_INIT = CntW'(MulLatency - 1);

  state_e            state;
  issue_latch_t      lat;
  logic [CntW-1:0]   cnt;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   mac_sum;
  logic              dec_accept;
  logic [2:0]        dec_op;
  logic [4:0]        dec_rd;
  logic              issue_commit_hit;
  logic              wait_commit_hit;

  cvxif_mac_decoder u_decoder (
    .instr  (issue_instr_i),
    .accept (dec_accept),
    .op     (dec_op),
    .rd     (dec_rd)
  );

  assign issue_accept_o    = dec_accept;
  assign issue_writeback_o = dec_accept;

  assign mac_sum          = acc + lat.rs1 * lat.rs2;
  assign issue_commit_hit = commit_valid_i && (commit_id_i == issue_id_i);
  assign wait_commit_hit  = commit_valid_i && (commit_id_i == lat.id);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      lat            <= '0;
      cnt            <= '0;
      acc            <= '0;
      issue_ready_o  <= 1'b1;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid_i && dec_accept) begin
            lat <= '{id: issue_id_i, rd: dec_rd, funct3: dec_op,
                     rs1: issue_rs1_i, rs2: issue_rs2_i};
            if (issue_commit_hit) begin
              // A same-cycle kill simply leaves us idle.
              if (!commit_kill_i) begin
                state         <= S_EXEC;
                cnt           <= CNT_INIT;
                issue_ready_o <= 1'b0;
              end
            end else begin
              state         <= S_WAIT_COMMIT;
              issue_ready_o <= 1'b0;
            end
          end
        end
        S_WAIT_COMMIT: begin
          if (wait_commit_hit) begin
            if (commit_kill_i) begin
              state         <= S_IDLE;
              issue_ready_o <= 1'b1;
            end else begin
              state <= S_EXEC;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            case (lat.funct3)
              FUNCT3_MAC: begin
                acc           <= mac_sum;
                result_data_o <= mac_sum;
              end
              FUNCT3_CLR: begin
                acc           <= '0;
                result_data_o <= acc;
              end
              default: result_data_o <= acc;
            endcase
            result_id_o    <= lat.id;
            result_rd_o    <= lat.rd;
            result_we_o    <= 1'b1;
            result_valid_o <= 1'b1;
            state          <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            result_we_o    <= 1'b0;
            issue_ready_o  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: begin
          state         <= S_IDLE;
          issue_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cvxif_mac_copro.sv
// Directed bench for cvxif_mac_copro with a result scoreboard fed by a reference accumulator.
module tb_cvxif_mac_copro;

  localparam int IdW = 4;
  localparam logic [6:0] OPC = 7'b0001011;

  typedef struct {
    logic [IdW-1:0] id;
    logic [4:0]     rd;
    logic [31:0]    data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [31:0]     issue_instr = '0;
  logic [IdW-1:0]  issue_id = '0;
  logic [31:0]     issue_rs1 = '0;
  logic [31:0]     issue_rs2 = '0;
  logic            issue_accept;
  logic            issue_writeback;
  logic            commit_valid = 1'b0;
  logic [IdW-1:0]  commit_id = '0;
  logic            commit_kill = 1'b0;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic [IdW-1:0]  result_id;
  logic [31:0]     result_data;
  logic [4:0]      result_rd;
  logic            result_we;

  int checks = 0;
  int errors = 0;
  logic [31:0] macc = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cvxif_mac_copro #(.XLEN(32), .IdWidth(IdW), .MulLatency(3)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs1_i       (issue_rs1),
    .issue_rs2_i       (issue_rs2),
    .issue_accept_o    (issue_accept),
    .issue_writeback_o (issue_writeback),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id),
    .result_data_o     (result_data),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rd);
    return {7'd0, 5'd0, 5'd0, f3, rd, opc};
  endfunction

  // Reference model: returns rd value and advances the bench accumulator.
  function automatic logic [31:0] model_exec(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000: begin macc = macc + a * b; r = macc; end
      3'b001: begin r = macc; macc = '0; end
      default: r = macc;
    endcase
    return r;
  endfunction

  // mode: 0 commit next cycle, 1 kill next cycle, 2 same-cycle commit, 3 same-cycle kill.
  // noise: a commit for id 3 is shown during WAIT_COMMIT before the real one.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [IdW-1:0] id, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input bit noise, input int hold);
    exp_t e;
    int n;
    logic [31:0] held;
    @(negedge clk);
    chk({tag, ".ready_in"}, issue_ready, 1);
    issue_valid  = 1'b1;
    issue_instr  = mk_instr(OPC, f3, rd);
    issue_id     = id;
    issue_rs1    = a;
    issue_rs2    = b;
    result_ready = (hold == 0);
    if (mode >= 2) begin
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = (mode == 3);
    end
    #1;
    chk({tag, ".accept"}, issue_accept, 1);
    chk({tag, ".writeback"}, issue_writeback, 1);
    if (mode < 2) begin
      @(negedge clk);
      issue_valid = 1'b0;
      if (noise) begin
        commit_valid = 1'b1;
        commit_id    = 4'd3;
        commit_kill  = 1'b0;
        @(negedge clk);
        commit_valid = 1'b0;
        chk({tag, ".noise_busy"}, issue_ready, 0);
        @(negedge clk);
        chk({tag, ".noise_no_result"}, result_valid, 0);
      end
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = (mode == 1);
    end
    if (mode == 0 || mode == 2) begin
      e.id   = id;
      e.rd   = rd;
      e.data = model_exec(f3, a, b);
      sb.push_back(e);
    end
    @(negedge clk);
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
    if (mode == 1 || mode == 3) begin
      chk({tag, ".kill_ready"}, issue_ready, 1);
      repeat (5) begin
        @(negedge clk);
        chk({tag, ".kill_no_result"}, result_valid, 0);
      end
      chk({tag, ".kill_acc"}, dut.acc, macc);
      return;
    end
    n = 1;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, 4);
    if (sb.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".data"}, result_data, e.data);
    chk({tag, ".id"}, {28'd0, result_id}, {28'd0, e.id});
    chk({tag, ".rd"}, {27'd0, result_rd}, {27'd0, e.rd});
    chk({tag, ".we"}, result_we, 1);
    held = e.data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, result_valid, 1);
      chk({tag, ".hold_data"}, result_data, held);
      chk({tag, ".hold_busy"}, issue_ready, 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".valid_drop"}, result_valid, 0);
    chk({tag, ".ready_back"}, issue_ready, 1);
    chk({tag, ".acc"}, dut.acc, macc);
    result_ready = 1'b0;
  endtask

  task automatic reject(input string tag, input logic [6:0] opc, input logic [2:0] f3);
    @(negedge clk);
    issue_valid = 1'b1;
    issue_instr = mk_instr(opc, f3, 5'd7);
    issue_id    = 4'd6;
    #1;
    chk({tag, ".accept"}, issue_accept, 0);
    chk({tag, ".writeback"}, issue_writeback, 0);
    @(negedge clk);
    issue_valid = 1'b0;
    chk({tag, ".ready"}, issue_ready, 1);
    repeat (5) @(negedge clk);
    chk({tag, ".no_result"}, result_valid, 0);
    chk({tag, ".ready_after"}, issue_ready, 1);
  endtask

  // Async reset while an instruction is in flight; wait_cycles selects EXEC or RESP.
  task automatic reset_mid(input string tag, input int wait_cycles);
    @(negedge clk);
    issue_valid  = 1'b1;
    issue_instr  = mk_instr(OPC, 3'b000, 5'd9);
    issue_id     = 4'd1;
    issue_rs1    = 32'd100;
    issue_rs2    = 32'd100;
    commit_valid = 1'b1;
    commit_id    = 4'd1;
    commit_kill  = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    repeat (wait_cycles) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".valid"}, result_valid, 0);
    chk({tag, ".ready"}, issue_ready, 1);
    chk({tag, ".acc"}, dut.acc, 0);
    chk({tag, ".we"}, result_we, 0);
    macc = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.ready", issue_ready, 1);
    chk("reset.valid", result_valid, 0);
    chk("reset.id", {28'd0, result_id}, 0);
    chk("reset.data", result_data, 0);
    chk("reset.rd", {27'd0, result_rd}, 0);
    chk("reset.we", result_we, 0);
    chk("reset.acc", dut.acc, 0);
    rst = 1'b0;

    do_op("mac_3x5", 3'b000, 5'd5, 4'd1, 32'd3, 32'd5, 0, 1'b0, 0);
    chk("mac_3x5.acc15", macc, 32'd15);
    do_op("mac_wrap", 3'b000, 5'd6, 4'd2, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 0);
    chk("mac_wrap.model", macc, 32'h0000_000D);
    do_op("mac_kill", 3'b000, 5'd8, 4'd4, 32'd7, 32'd7, 1, 1'b0, 0);

    reject("bad_f3", OPC, 3'b111);
    reject("bad_opc", 7'b0101011, 3'b000);

    do_op("clr_13", 3'b001, 5'd10, 4'd7, 32'd0, 32'd0, 0, 1'b0, 0);
    do_op("mac_42", 3'b000, 5'd11, 4'd8, 32'd6, 32'd7, 0, 1'b0, 0);
    do_op("clr_hold", 3'b001, 5'd12, 4'd10, 32'd0, 32'd0, 0, 1'b0, 5);
    do_op("rd_zero", 3'b010, 5'd13, 4'd11, 32'd0, 32'd0, 0, 1'b0, 0);

    do_op("noise_mac", 3'b000, 5'd14, 4'd5, 32'd10, 32'd10, 0, 1'b1, 0);
    do_op("same_mac", 3'b000, 5'd15, 4'd9, 32'd2, 32'd3, 2, 1'b0, 0);
    do_op("same_kill", 3'b000, 5'd16, 4'd9, 32'd50, 32'd50, 3, 1'b0, 0);
    do_op("rd_106", 3'b010, 5'd17, 4'd12, 32'd0, 32'd0, 0, 1'b0, 0);
    chk("rd_106.model", macc, 32'd106);

    reset_mid("rst_exec", 2);
    reset_mid("rst_resp", 5);
    do_op("rd_after_rst", 3'b010, 5'd18, 4'd13, 32'd0, 32'd0, 0, 1'b0, 0);
    do_op("mac_after_rst", 3'b000, 5'd19, 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 0);

    chk("sb.empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
